vsm_stream: RTL and testbench

- Parametrised vector-scalar multiply-accumulate engine; successor to the fixed 8-bit MAC-array vector-scalar multiplier.
- Each accepted beat carries LANES signed operands a[i] and one shared signed scalar b. Each lane accumulates a[i]*b over ACCUMULATIONS beats, then emits one scaled LANES-wide result vector.
- Adds a valid/ready stream handshake, a beat counter, a single-entry output register with back-pressure, abort (clear) and configurable output scaling.
- Sits between the weight/activation streamer and the activation/requant stage of the accelerator datapath.

---
 rtl/vsm_stream.sv | 116 +++++++++++
 tb/tb_vsm_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsm_stream.sv
// Vector-scalar multiply-accumulate stream engine: LANES products summed over ACCUMULATIONS beats.
// Define VSM_SAT_EN for saturating output narrowing and a sticky sat_flag port.
module vsm_stream #(
  parameter int LANES         = 6,
  parameter int IN_WIDTH      = 8,
  parameter int ACC_WIDTH     = 20,
  parameter int OUT_WIDTH     = 8,
  parameter int ACCUMULATIONS = 3,
  parameter int SHIFT         = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IN_WIDTH-1:0]    a,
  input  logic [IN_WIDTH-1:0]          b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out,
`ifdef VSM_SAT_EN
  output logic                         sat_flag,
`endif
  output logic                         busy
);

  localparam int CNT_W = (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCUMULATIONS - 1);

  logic [CNT_W-1:0]            beat_cnt;
  logic [CNT_W-1:0]            beat_cnt_next;
  logic signed [ACC_WIDTH-1:0] acc      [LANES];
  logic signed [ACC_WIDTH-1:0] acc_next [LANES];
  logic [LANES*OUT_WIDTH-1:0]  out_next;
  logic                        last_beat;
  logic                        accept;
  logic                        final_beat;
`ifdef VSM_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -OUT_MAX - ACC_WIDTH'(1);
  logic any_sat;
`endif

  // Only the final beat has to wait for the held output; earlier beats keep accumulating.
  assign last_beat  = (beat_cnt == LAST);
  assign in_ready   = !clear && !(out_valid && !out_ready && last_beat);
  assign accept     = in_valid && in_ready;
  assign final_beat = accept && last_beat;

  always_comb begin
    beat_cnt_next = beat_cnt;
    if (clear)
      beat_cnt_next = '0;
    else if (accept)
      beat_cnt_next = last_beat ? '0 : beat_cnt + CNT_W'(1);
  end

  // First beat of a vector loads the product instead of adding, so no explicit acc clear is needed.
  always_comb begin : datapath
    logic signed [2*IN_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  shifted;
    prod     = '0;
    shifted  = '0;
    out_next = '0;
`ifdef VSM_SAT_EN
    any_sat  = 1'b0;
`endif
    for (int i = 0; i < LANES; i++) begin
      prod        = $signed(a[i*IN_WIDTH +: IN_WIDTH]) * $signed(b);
      acc_next[i] = (beat_cnt == '0) ? ACC_WIDTH'(prod) : acc[i] + ACC_WIDTH'(prod);
      shifted     = acc_next[i] >>> SHIFT;
`ifdef VSM_SAT_EN
      if (shifted > OUT_MAX) begin
        out_next[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(OUT_MAX);
        any_sat = 1'b1;
      end else if (shifted < OUT_MIN) begin
        out_next[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(OUT_MIN);
        any_sat = 1'b1;
      end else begin
        out_next[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(shifted);
      end
`else
      out_next[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(shifted);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
`ifdef VSM_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      beat_cnt <= beat_cnt_next;
      busy     <= (beat_cnt_next != '0);
      if (accept)
        for (int i = 0; i < LANES; i++) acc[i] <= acc_next[i];
      // A new result replaces a consumed one on the same edge without a bubble.
      if (final_beat) begin
        out       <= out_next;
        out_valid <= 1'b1;
`ifdef VSM_SAT_EN
        sat_flag  <= sat_flag | any_sat;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vsm_stream.sv
// Self-checking bench for vsm_stream: directed scenarios plus a randomized run against a
// beat-level reference model (per-vector sums, single-entry output slot).
module tb_vsm_stream;
  localparam int LANES = 6;
  localparam int ACCS  = 3;
  localparam int SHIFT = 0;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, out_ready;
  logic [47:0] a;
  logic [7:0]  b;
  logic        in_ready, out_valid, busy;
  logic [47:0] out;

  logic        s_in_valid, s_in_ready, s_out_valid, s_busy;
  logic [47:0] s_a, s_out;
  logic [7:0]  s_b;
`ifdef VSM_SAT_EN
  logic        sat_flag, s_sat_flag;
`endif

  int pass_cnt = 0;
  int total    = 0;

  bit          m_valid = 0;
  logic [47:0] m_out   = '0;
  int          m_cnt   = 0;
  int          m_sum [LANES];
  bit          m_sat   = 0;

  always #5 clk = ~clk;

  vsm_stream dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
`ifdef VSM_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  vsm_stream #(.SHIFT(2)) dut_shift (
    .clk(clk), .reset(reset), .clear(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(1'b1), .out(s_out),
`ifdef VSM_SAT_EN
    .sat_flag(s_sat_flag),
`endif
    .busy(s_busy)
  );

  function automatic logic [47:0] rep(input logic [7:0] x);
    return {LANES{x}};
  endfunction

  function automatic int wrap_acc(input int s);
    return (s <<< 12) >>> 12;
  endfunction

  function automatic logic [7:0] narrow(input int v);
`ifdef VSM_SAT_EN
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
`endif
    return v[7:0];
  endfunction

  task automatic drive(input bit v, input logic [47:0] av, input logic [7:0] bv,
                       input bit ordy, input bit clr);
    in_valid  = v;
    a         = av;
    b         = bv;
    out_ready = ordy;
    clear     = clr;
  endtask

  // Advances one clock and updates the reference model with what the edge did.
  task automatic tick();
    bit mr, acc_b;
    int p, v;
    mr    = !clear && !(m_valid && !out_ready && m_cnt == ACCS - 1);
    acc_b = in_valid && mr;
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 0; m_out = '0; m_cnt = 0; m_sat = 0;
    end else begin
      if (clear) m_cnt = 0;
      if (m_valid && out_ready) m_valid = 0;
      if (acc_b) begin
        for (int i = 0; i < LANES; i++) begin
          p = $signed(a[i*8 +: 8]) * $signed(b);
          m_sum[i] = (m_cnt == 0) ? wrap_acc(p) : wrap_acc(m_sum[i] + p);
          if (m_cnt == ACCS - 1) begin
            v = m_sum[i] >>> SHIFT;
            m_out[i*8 +: 8] = narrow(v);
            if (v > 127 || v < -128) m_sat = 1;
          end
        end
        if (m_cnt == ACCS - 1) m_valid = 1;
        m_cnt = (m_cnt == ACCS - 1) ? 0 : m_cnt + 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, '0, '0, 1, 0);
    s_in_valid = 0; s_a = '0; s_b = '0;
    tick();
    tick();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (out !== 48'h0) $display("[TB] FAIL reset_out: got %h want 0", out); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
`ifdef VSM_SAT_EN
    total++; if (sat_flag !== 1'b0) $display("[TB] FAIL reset_sat_flag: got %b want 0", sat_flag); else pass_cnt++;
`endif
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin
      drive(1, rep(8'd2), 8'd3, 1, 0);
      tick();
      if (k == 0) begin
        total++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b want 1", busy); else pass_cnt++;
      end
      if (k < 2) begin
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_early_valid: got %b want 0", out_valid); else pass_cnt++;
      end
    end
    drive(0, '0, '0, 1, 0);
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b want 1", out_valid); else pass_cnt++;
    total++; if (out !== rep(8'h12)) $display("[TB] FAIL basic_out: got %h want %h", out, rep(8'h12)); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_end: got %b want 0", busy); else pass_cnt++;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_pulse: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_shift();
    for (int k = 0; k < 3; k++) begin
      s_in_valid = 1; s_a = rep(8'hF9); s_b = 8'd3;
      @(posedge clk); #1;
    end
    s_in_valid = 0;
    total++; if (s_out_valid !== 1'b1) $display("[TB] FAIL shift_valid: got %b want 1", s_out_valid); else pass_cnt++;
    total++; if (s_out !== rep(8'hF0)) $display("[TB] FAIL shift_out: got %h want %h", s_out, rep(8'hF0)); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [47:0] exp_pos;
`ifdef VSM_SAT_EN
    exp_pos = rep(8'h7F);
`else
    exp_pos = rep(8'h03);
`endif
    for (int k = 0; k < 3; k++) begin drive(1, rep(8'd127), 8'd127, 1, 0); tick(); end
    drive(0, '0, '0, 1, 0);
    total++; if (out !== exp_pos) $display("[TB] FAIL ovf_pos_out: got %h want %h", out, exp_pos); else pass_cnt++;
`ifdef VSM_SAT_EN
    total++; if (sat_flag !== 1'b1) $display("[TB] FAIL ovf_sat_flag: got %b want 1", sat_flag); else pass_cnt++;
`endif
    for (int k = 0; k < 3; k++) begin drive(1, rep(8'h80), 8'd127, 1, 0); tick(); end
    drive(0, '0, '0, 1, 0);
    total++; if (out !== rep(8'h80)) $display("[TB] FAIL ovf_neg_out: got %h want %h", out, rep(8'h80)); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin drive(1, rep(8'd2), 8'd3, 0, 0); tick(); end
    for (int k = 0; k < 2; k++) begin
      drive(1, rep(8'd1), 8'd1, 0, 0);
      #1;
      total++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_nonfinal_ready: got %b want 1", in_ready); else pass_cnt++;
      tick();
    end
    drive(1, rep(8'd1), 8'd1, 0, 0);
    #1;
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_final_stall: got %b want 0", in_ready); else pass_cnt++;
    tick();
    total++; if (out !== rep(8'h12)) $display("[TB] FAIL bp_hold_out: got %h want %h", out, rep(8'h12)); else pass_cnt++;
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid: got %b want 1", out_valid); else pass_cnt++;
    drive(1, rep(8'd1), 8'd1, 1, 0);
    #1;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); else pass_cnt++;
    tick();
    drive(0, '0, '0, 1, 0);
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_next_valid: got %b want 1", out_valid); else pass_cnt++;
    total++; if (out !== rep(8'h03)) $display("[TB] FAIL bp_next_out: got %h want %h", out, rep(8'h03)); else pass_cnt++;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_clear();
    for (int k = 0; k < 2; k++) begin drive(1, rep(8'd5), 8'd1, 1, 0); tick(); end
    total++; if (busy !== 1'b1) $display("[TB] FAIL clr_busy_before: got %b want 1", busy); else pass_cnt++;
    drive(1, rep(8'd5), 8'd1, 1, 1);
    #1;
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL clr_in_ready: got %b want 0", in_ready); else pass_cnt++;
    tick();
    total++; if (busy !== 1'b0) $display("[TB] FAIL clr_busy_after: got %b want 0", busy); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL clr_no_output: got %b want 0", out_valid); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin drive(1, rep(8'd1), 8'd1, 1, 0); tick(); end
    drive(0, '0, '0, 1, 0);
    total++; if (out !== rep(8'h03)) $display("[TB] FAIL clr_result: got %h want %h", out, rep(8'h03)); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin drive(1, rep(8'd2), 8'd3, 0, 0); tick(); end
    for (int k = 0; k < 2; k++) begin drive(1, rep(8'd1), 8'd1, 0, 0); tick(); end
    drive(0, '0, '0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL rmid_valid: got %b want 0", out_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL rmid_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (out !== 48'h0) $display("[TB] FAIL rmid_out: got %h want 0", out); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin drive(1, rep(8'd4), 8'd1, 1, 0); tick(); end
    drive(0, '0, '0, 1, 0);
    total++; if (out !== rep(8'h0C)) $display("[TB] FAIL rmid_fresh: got %h want %h", out, rep(8'h0C)); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    bit exp_ready;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      #1;
      exp_ready = !clear && !(m_valid && !out_ready && m_cnt == ACCS - 1);
      total++; if (in_ready !== exp_ready) $display("[TB] FAIL rnd_in_ready: got %b want %b", in_ready, exp_ready); else pass_cnt++;
      tick();
      total++; if (out_valid !== m_valid) $display("[TB] FAIL rnd_valid: got %b want %b", out_valid, m_valid); else pass_cnt++;
      if (m_valid) begin
        total++; if (out !== m_out) $display("[TB] FAIL rnd_out: got %h want %h", out, m_out); else pass_cnt++;
      end
      total++; if (busy !== (m_cnt != 0)) $display("[TB] FAIL rnd_busy: got %b want %b", busy, m_cnt != 0); else pass_cnt++;
`ifdef VSM_SAT_EN
      total++; if (sat_flag !== m_sat) $display("[TB] FAIL rnd_sat_flag: got %b want %b", sat_flag, m_sat); else pass_cnt++;
`endif
    end
    drive(0, '0, '0, 1, 0);
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) m_sum[i] = 0;
    test_reset();
    test_shift();
    test_basic();
    test_overflow();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
